// File: rtl/chunked_adder_if.sv
// chunked_adder_if: handshake and operand/result bundle for chunked_adder.
//   start, sub, a, b : request and operands, driven by the requester (master)
//   sat              : saturate-on-overflow request (only with CHUNKED_ADDER_SAT_EN)
//   busy, done       : operation in progress / one-cycle completion pulse
//   sum, ovf         : {carry-out, result} and signed overflow, held until next completion
// WIDTH must match the WIDTH of the chunked_adder instance it connects to.
interface chunked_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   sum;
  logic             ovf;
`ifdef CHUNKED_ADDER_SAT_EN
  logic             sat;

  modport master (output start, sub, a, b, sat, input busy, done, sum, ovf);
  modport slave  (input start, sub, a, b, sat, output busy, done, sum, ovf);
`else
  modport master (output start, sub, a, b, input busy, done, sum, ovf);
  modport slave  (input start, sub, a, b, output busy, done, sum, ovf);
`endif
endinterface

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder/subtractor, carry chain split into CHUNK-bit
// slices processed one per clock.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : chunked_adder_if.slave (start/sub/a/b in, busy/done/sum/ovf out)
// Optional feature macro: CHUNKED_ADDER_SAT_EN adds bus.sat; when sat was sampled
// high and the result overflows, sum[WIDTH-1:0] is clamped (carry and ovf stay raw).
//
// state | meaning
// IDLE  | waiting for start; done may be high for one cycle here
// RUN   | one slice summed per clock, busy high
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic          clk,
  input logic          rst_n,
  chunked_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [WIDTH-1:0] CLAMP_POS = {WIDTH{1'b1}} >> 1;
  localparam logic [WIDTH-1:0] CLAMP_NEG = ~CLAMP_POS;

  logic [0:0]       state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] acc;
  logic             sign_a;
  logic             sign_b;
  logic             done_q;
  logic [WIDTH:0]   sum_q;
  logic             ovf_q;
`ifdef CHUNKED_ADDER_SAT_EN
  logic             sat_q;
`endif

  logic [CHUNK:0]   slice;
  logic [WIDTH-1:0] next_acc;
  logic [WIDTH-1:0] result;
  logic             ovf_raw;
  int               base;

  // Current slice plus the accumulator as it will look after this edge; the
  // completing edge takes the final result from next_acc so sum never shows
  // a partially built value.
  always_comb begin
    base     = int'(idx) * CHUNK;
    slice    = {1'b0, opa[base +: CHUNK]} + {1'b0, opb[base +: CHUNK]}
             + {{CHUNK{1'b0}}, carry};
    next_acc = acc;
    next_acc[base +: CHUNK] = slice[CHUNK-1:0];
    ovf_raw  = (sign_a == sign_b) && (next_acc[WIDTH-1] != sign_a);
    result   = next_acc;
`ifdef CHUNKED_ADDER_SAT_EN
    if (sat_q && ovf_raw) begin
      result = sign_a ? CLAMP_NEG : CLAMP_POS;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      opa    <= '0;
      opb    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      acc    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      ovf_q  <= 1'b0;
`ifdef CHUNKED_ADDER_SAT_EN
      sat_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          // Subtraction is a + ~b + 1: invert B here, carry-in supplies the +1.
          opa    <= bus.a;
          opb    <= bus.sub ? ~bus.b : bus.b;
          carry  <= bus.sub;
          idx    <= '0;
          acc    <= '0;
          sign_a <= bus.a[WIDTH-1];
          sign_b <= bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
`ifdef CHUNKED_ADDER_SAT_EN
          sat_q  <= bus.sat;
`endif
          state  <= RUN;
        end
      end else begin
        acc   <= next_acc;
        carry <= slice[CHUNK];
        if (idx == LAST_IDX) begin
          state  <= IDLE;
          idx    <= '0;
          done_q <= 1'b1;
          sum_q  <= {slice[CHUNK], result};
          ovf_q  <= ovf_raw;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: directed and randomized checks of chunked_adder (16/4) plus an
// exhaustive 4-bit sweep over CHUNK = 1, 2, 4, all against an arithmetic model.
module tb_chunked_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chunked_adder_if #(.WIDTH(16)) bus ();
  chunked_adder_if #(.WIDTH(4))  s1 ();
  chunked_adder_if #(.WIDTH(4))  s2 ();
  chunked_adder_if #(.WIDTH(4))  s4 ();

  chunked_adder #(.WIDTH(16), .CHUNK(4)) dut    (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  chunked_adder #(.WIDTH(4),  .CHUNK(1)) dut_c1 (.clk(clk), .rst_n(rst_n), .bus(s1.slave));
  chunked_adder #(.WIDTH(4),  .CHUNK(2)) dut_c2 (.clk(clk), .rst_n(rst_n), .bus(s2.slave));
  chunked_adder #(.WIDTH(4),  .CHUNK(4)) dut_c4 (.clk(clk), .rst_n(rst_n), .bus(s4.slave));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: unsigned arithmetic for result/carry, signed range test for overflow.
  function automatic void model(input int w, input longint av, input longint bv,
                                input bit s, input bit sat,
                                output longint es, output bit eo);
    longint full, half, low, carry, sa, sb, r;
    full = longint'(1) << w;
    half = longint'(1) << (w - 1);
    if (!s) begin
      carry = ((av + bv) >= full) ? 1 : 0;
      low   = (av + bv) % full;
    end else begin
      carry = (av >= bv) ? 1 : 0;
      low   = (av - bv + full) % full;
    end
    sa = (av >= half) ? av - full : av;
    sb = (bv >= half) ? bv - full : bv;
    r  = s ? sa - sb : sa + sb;
    eo = (r > half - 1) || (r < -half);
    if (sat && eo) low = (r > 0) ? half - 1 : half;
    es = carry * full + low;
  endfunction

  function automatic bit sat_eff(input bit sat);
`ifdef CHUNKED_ADDER_SAT_EN
    return sat;
`else
    return 1'b0;
`endif
  endfunction

  // Called at #1 after an edge; start is sampled on the next edge.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv,
                       input bit s, input bit sat);
    bus.a = av; bus.b = bv; bus.sub = s; bus.start = 1'b1;
`ifdef CHUNKED_ADDER_SAT_EN
    bus.sat = sat;
`endif
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0; busy_cnt = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op_check(input string tag, input logic [15:0] av,
                          input logic [15:0] bv, input bit s, input bit sat);
    int lat, bc;
    longint es;
    bit eo;
    issue(av, bv, s, sat);
    wait_done(lat, bc);
    model(16, longint'(av), longint'(bv), s, sat_eff(sat), es, eo);
    check({tag, " latency"}, lat, 4);
    check({tag, " busy cycles"}, bc, 4);
    check({tag, " sum"}, bus.sum, es);
    check({tag, " ovf"}, bus.ovf, eo);
  endtask

  initial begin
    int lat, bc, cnt;
    longint es, prev;
    bit eo;
    bus.start = 0; bus.sub = 0; bus.a = '0; bus.b = '0;
    s1.start = 0;  s1.sub = 0;  s1.a = '0;  s1.b = '0;
    s2.start = 0;  s2.sub = 0;  s2.a = '0;  s2.b = '0;
    s4.start = 0;  s4.sub = 0;  s4.a = '0;  s4.b = '0;
`ifdef CHUNKED_ADDER_SAT_EN
    bus.sat = 0; s1.sat = 0; s2.sat = 0; s4.sat = 0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset sum",  bus.sum, 0);
    check("reset ovf",  bus.ovf, 0);

    op_check("add 1+ffff", 16'h0001, 16'hFFFF, 1'b0, 1'b0);
    check("add 1+ffff sum const", bus.sum, 17'h10000);
    @(posedge clk); #1;
    check("done one cycle", bus.done, 0);
    op_check("sub 5-7", 16'h0005, 16'h0007, 1'b1, 1'b0);
    check("sub 5-7 sum const", bus.sum, 17'h0FFFE);
    op_check("sub 8000-1", 16'h8000, 16'h0001, 1'b1, 1'b0);
    check("sub 8000-1 ovf const", bus.ovf, 1);
`ifdef CHUNKED_ADDER_SAT_EN
    op_check("sub 8000-1 sat", 16'h8000, 16'h0001, 1'b1, 1'b1);
    check("sat clamp low", bus.sum, 17'h18000);
`endif

    // Second start during busy with operands changed: must be ignored.
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = '0; bus.b = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat, bc);
    check("ignored start latency", lat, 2);
    check("ignored start sum", bus.sum, 17'h08000);
    check("ignored start ovf", bus.ovf, 1);
    // Start in the done cycle is accepted.
    issue(16'h1234, 16'h0101, 1'b0, 1'b0);
    check("start in done cycle busy", bus.busy, 1);
    check("held sum during run", bus.sum, 17'h08000);
    wait_done(lat, bc);
    check("start in done cycle latency", lat, 4);
    check("start in done cycle sum", bus.sum, 17'h01335);

    // Reset in the second RUN cycle.
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort busy", bus.busy, 0);
    check("abort sum",  bus.sum, 0);
    check("abort done", bus.done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.done) cnt++;
    end
    check("abort no done", cnt, 0);

    // Random ops, issued back-to-back in the done cycle.
    prev = 0;
    for (int i = 0; i < 40; i++) begin
      logic [15:0] av, bv;
      bit s, st;
      av = 16'($urandom_range(0, 65535));
      bv = 16'($urandom_range(0, 65535));
      s  = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      issue(av, bv, s, st);
      check($sformatf("rand%0d held sum", i), bus.sum, prev);
      wait_done(lat, bc);
      model(16, longint'(av), longint'(bv), s, sat_eff(st), es, eo);
      check($sformatf("rand%0d latency", i), lat, 4);
      check($sformatf("rand%0d sum a=%h b=%h sub=%0d", i, av, bv, s), bus.sum, es);
      check($sformatf("rand%0d ovf", i), bus.ovf, eo);
      prev = es;
    end

    // Exhaustive 4-bit sweep across chunk sizes.
    for (int s = 0; s < 2; s++) begin
      for (int av = 0; av < 16; av++) begin
        for (int bv = 0; bv < 16; bv++) begin
          int l1, l2, l4;
          bit st;
          st = 1'($urandom_range(0, 1));
          s1.a = 4'(av); s1.b = 4'(bv); s1.sub = s[0]; s1.start = 1'b1;
          s2.a = 4'(av); s2.b = 4'(bv); s2.sub = s[0]; s2.start = 1'b1;
          s4.a = 4'(av); s4.b = 4'(bv); s4.sub = s[0]; s4.start = 1'b1;
`ifdef CHUNKED_ADDER_SAT_EN
          s1.sat = st; s2.sat = st; s4.sat = st;
`endif
          @(posedge clk); #1;
          s1.start = 1'b0; s2.start = 1'b0; s4.start = 1'b0;
          l1 = -1; l2 = -1; l4 = -1;
          for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (s1.done && l1 < 0) l1 = c;
            if (s2.done && l2 < 0) l2 = c;
            if (s4.done && l4 < 0) l4 = c;
          end
          model(4, longint'(av), longint'(bv), s[0], sat_eff(st), es, eo);
          check($sformatf("c1 lat a=%0d b=%0d sub=%0d", av, bv, s), l1, 4);
          check($sformatf("c2 lat a=%0d b=%0d sub=%0d", av, bv, s), l2, 2);
          check($sformatf("c4 lat a=%0d b=%0d sub=%0d", av, bv, s), l4, 1);
          check($sformatf("c1 sum a=%0d b=%0d sub=%0d", av, bv, s), s1.sum, es);
          check($sformatf("c2 sum a=%0d b=%0d sub=%0d", av, bv, s), s2.sum, es);
          check($sformatf("c4 sum a=%0d b=%0d sub=%0d", av, bv, s), s4.sum, es);
          check($sformatf("c1 ovf a=%0d b=%0d sub=%0d", av, bv, s), s1.ovf, eo);
          check($sformatf("c2 ovf a=%0d b=%0d sub=%0d", av, bv, s), s2.ovf, eo);
          check($sformatf("c4 ovf a=%0d b=%0d sub=%0d", av, bv, s), s4.ovf, eo);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
